// File: rtl/phase1_datapath.sv
// Phase-1 single-bus CPU datapath.
// General registers R1/R3/R5 and the special registers PC, IR, MAR, MDR, Y and
// a 64-bit Z all share one 32-bit bus. A combinational ALU takes A from Y and
// B from the bus and produces a 64-bit result for Z. All control comes from an
// external sequencer; this block holds data only and has no state machine.
// PC, IR and MAR contents are brought out as well so the fetch path can be
// observed from outside.
module phase1_datapath (
  input  logic        Clock,
  input  logic        Clear,
  // general register load enables
  input  logic        R1in,
  input  logic        R3in,
  input  logic        R5in,
  // special register load enables
  input  logic        MARin,
  input  logic        Zin,
  input  logic        PCin,
  input  logic        MDRin,
  input  logic        IRin,
  input  logic        Yin,
  input  logic        IncrementPC,
  // bus drive selects
  input  logic        PCout,
  input  logic        ZLOout,
  input  logic        MDRout,
  input  logic        R3out,
  input  logic        R5out,
  // memory interface and ALU operation
  input  logic        Read,
  input  logic [4:0]  ALUControl,
  input  logic [31:0] Mdatain,
  // register contents and combinational observation points
  output logic [31:0] R1_data_out,
  output logic [31:0] R3_data_out,
  output logic [31:0] R5_data_out,
  output logic [31:0] big_boy_bus,
  output logic [31:0] MDR_data_in,
  output logic [31:0] MDR_data_out,
  output logic [31:0] Y_data_out,
  output logic [63:0] Z_data_out,
  output logic [31:0] PC_data_out,
  output logic [31:0] IR_data_out,
  output logic [31:0] MAR_data_out
);

  // ALU operation codes; anything not listed yields a zero result.
  typedef enum logic [4:0] {
    ALU_ADD  = 5'b00000,
    ALU_SUB  = 5'b00001,
    ALU_AND  = 5'b00010,
    ALU_OR   = 5'b00011,
    ALU_SHL  = 5'b00100,
    ALU_SHR  = 5'b00101,
    ALU_SHRA = 5'b00110,
    ALU_ROR  = 5'b00111,
    ALU_ROL  = 5'b01000,
    ALU_MUL  = 5'b01001,
    ALU_DIV  = 5'b01010,
    ALU_NEG  = 5'b01011,
    ALU_NOT  = 5'b01100
  } alu_op_e;

  // ---------------------------------------------------------------------------
  // Register state
  // ---------------------------------------------------------------------------
  logic [31:0] r1_q,  r1_d;
  logic [31:0] r3_q,  r3_d;
  logic [31:0] r5_q,  r5_d;
  logic [31:0] pc_q,  pc_d;
  logic [31:0] ir_q,  ir_d;
  logic [31:0] mar_q, mar_d;
  logic [31:0] mdr_q, mdr_d;
  logic [31:0] y_q,   y_d;
  logic [63:0] z_q,   z_d;

  // ---------------------------------------------------------------------------
  // Shared bus and MDR input mux
  // ---------------------------------------------------------------------------
  logic [31:0] bus;
  logic [31:0] mdr_mux;

  // Bus source select: the sequencer drives at most one select, the priority
  // order only settles accidental overlaps; nothing selected reads as zero.
  always_comb begin : bus_mux
    bus = '0;
    if (MDRout)      bus = mdr_q;
    else if (PCout)  bus = pc_q;
    else if (ZLOout) bus = z_q[31:0];
    else if (R3out)  bus = r3_q;
    else if (R5out)  bus = r5_q;
  end

  // MDR loads from memory during a read, otherwise from the bus.
  assign mdr_mux = Read ? Mdatain : bus;

  // ---------------------------------------------------------------------------
  // ALU: A = Y, B = bus
  // ---------------------------------------------------------------------------
  logic [4:0]         shamt;
  logic [5:0]         rol_amt;
  logic [63:0]        y_dbl;
  logic [31:0]        ror_word;
  logic [31:0]        rol_word;
  logic signed [63:0] y_sx;
  logic signed [63:0] bus_sx;
  logic signed [63:0] product;
  logic [31:0]        quotient;
  logic [31:0]        remainder;
  logic [63:0]        alu_result;

  assign shamt    = bus[4:0];
  // Rotating left by n is rotating right by 32-n; n = 0 shifts the doubled
  // word by a full 32, which lands the untouched Y in the low half.
  assign rol_amt  = 6'd32 - {1'b0, shamt};
  assign y_dbl    = {y_q, y_q};
  assign ror_word = 32'(y_dbl >> shamt);
  assign rol_word = 32'(y_dbl >> rol_amt);

  // Operands sign-extended to 64 bits: the product is exact, and the
  // -2^31 / -1 corner cannot overflow inside the divider.
  assign y_sx      = {{32{y_q[31]}}, y_q};
  assign bus_sx    = {{32{bus[31]}}, bus};
  assign product   = y_sx * bus_sx;
  assign quotient  = 32'(y_sx / bus_sx);
  assign remainder = 32'(y_sx % bus_sx);

  // Operation decode; 32-bit results are zero-extended into the 64-bit Z.
  always_comb begin : alu
    alu_result = '0;
    case (ALUControl)
      ALU_ADD:  alu_result = {32'd0, y_q + bus};
      ALU_SUB:  alu_result = {32'd0, y_q - bus};
      ALU_AND:  alu_result = {32'd0, y_q & bus};
      ALU_OR:   alu_result = {32'd0, y_q | bus};
      ALU_SHL:  alu_result = {32'd0, y_q << shamt};
      ALU_SHR:  alu_result = {32'd0, y_q >> shamt};
      ALU_SHRA: alu_result = {32'd0, 32'($signed(y_q) >>> shamt)};
      ALU_ROR:  alu_result = {32'd0, ror_word};
      ALU_ROL:  alu_result = {32'd0, rol_word};
      ALU_MUL:  alu_result = product;
      ALU_DIV:  alu_result = (bus == 32'd0) ? 64'd0 : {remainder, quotient};
      ALU_NEG:  alu_result = {32'd0, 32'd0 - bus};
      ALU_NOT:  alu_result = {32'd0, ~bus};
      default:  alu_result = '0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Next-state selection
  // ---------------------------------------------------------------------------

  // Each register holds unless its enable is high; PC increment beats a bus load.
  always_comb begin : next_state
    // NOTE: every _d is given its hold value before any condition, so no path
    // through this block leaves a variable unassigned and no latch is inferred.
    r1_d  = r1_q;
    r3_d  = r3_q;
    r5_d  = r5_q;
    pc_d  = pc_q;
    ir_d  = ir_q;
    mar_d = mar_q;
    mdr_d = mdr_q;
    y_d   = y_q;
    z_d   = z_q;

    if (R1in)  r1_d  = bus;
    if (R3in)  r3_d  = bus;
    if (R5in)  r5_d  = bus;
    if (IRin)  ir_d  = bus;
    if (MARin) mar_d = bus;
    if (Yin)   y_d   = bus;
    if (MDRin) mdr_d = mdr_mux;
    if (Zin)   z_d   = alu_result;
    if (PCin)  pc_d  = IncrementPC ? pc_q + 32'd1 : bus;
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------

  // Register bank with asynchronous clear; load enables have no effect while
  // Clear is high because the reset branch wins.
  always_ff @(posedge Clock or posedge Clear) begin : regs
    // NOTE: non-blocking assignments make every register sample pre-edge
    // values, which is what lets a register drive the bus and reload from it
    // in the same cycle without a loop or an ordering race.
    if (Clear) begin
      r1_q  <= '0;
      r3_q  <= '0;
      r5_q  <= '0;
      pc_q  <= '0;
      ir_q  <= '0;
      mar_q <= '0;
      mdr_q <= '0;
      y_q   <= '0;
      z_q   <= '0;
    end else begin
      r1_q  <= r1_d;
      r3_q  <= r3_d;
      r5_q  <= r5_d;
      pc_q  <= pc_d;
      ir_q  <= ir_d;
      mar_q <= mar_d;
      mdr_q <= mdr_d;
      y_q   <= y_d;
      z_q   <= z_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign R1_data_out  = r1_q;
  assign R3_data_out  = r3_q;
  assign R5_data_out  = r5_q;
  assign big_boy_bus  = bus;
  assign MDR_data_in  = mdr_mux;
  assign MDR_data_out = mdr_q;
  assign Y_data_out   = y_q;
  assign Z_data_out   = z_q;
  assign PC_data_out  = pc_q;
  assign IR_data_out  = ir_q;
  assign MAR_data_out = mar_q;

endmodule

// File: tb/tb_phase1_datapath.sv
// Self-checking bench for phase1_datapath. The driver plays the sequencer,
// updates a behavioural model of the register file and pushes expected
// values into a scoreboard queue; a separate monitor pops and compares them
// against the DUT on every falling edge (or on demand during a reset).
module tb_phase1_datapath;

  logic        Clock = 1'b0;
  logic        Clear;
  logic        R1in, R3in, R5in;
  logic        MARin, Zin, PCin, MDRin, IRin, Yin, IncrementPC;
  logic        PCout, ZLOout, MDRout, R3out, R5out;
  logic        Read;
  logic [4:0]  ALUControl;
  logic [31:0] Mdatain;
  logic [31:0] R1_data_out, R3_data_out, R5_data_out;
  logic [31:0] big_boy_bus, MDR_data_in, MDR_data_out, Y_data_out;
  logic [63:0] Z_data_out;
  logic [31:0] PC_data_out, IR_data_out, MAR_data_out;

  always #5 Clock = ~Clock;

  phase1_datapath dut (
    .Clock(Clock), .Clear(Clear),
    .R1in(R1in), .R3in(R3in), .R5in(R5in),
    .MARin(MARin), .Zin(Zin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin),
    .IncrementPC(IncrementPC),
    .PCout(PCout), .ZLOout(ZLOout), .MDRout(MDRout), .R3out(R3out), .R5out(R5out),
    .Read(Read), .ALUControl(ALUControl), .Mdatain(Mdatain),
    .R1_data_out(R1_data_out), .R3_data_out(R3_data_out), .R5_data_out(R5_data_out),
    .big_boy_bus(big_boy_bus), .MDR_data_in(MDR_data_in), .MDR_data_out(MDR_data_out),
    .Y_data_out(Y_data_out), .Z_data_out(Z_data_out),
    .PC_data_out(PC_data_out), .IR_data_out(IR_data_out), .MAR_data_out(MAR_data_out)
  );

  // One sequencer step worth of control inputs.
  typedef struct packed {
    logic r1in, r3in, r5in, marin, zin, pcin, mdrin, irin, yin, incpc;
    logic pcout, zloout, mdrout, r3out, r5out, read;
    logic [4:0]  alu;
    logic [31:0] mdata;
  } ctrl_t;

  typedef enum {E_BUS, E_MDRIN, E_R1, E_R3, E_R5, E_PC, E_IR, E_MAR, E_MDR, E_Y, E_Z} sel_e;

  typedef struct {
    sel_e        sel;
    logic [63:0] val;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  event sample_ev;

  // Reference model state.
  logic [31:0] m_r1, m_r3, m_r5, m_pc, m_ir, m_mar, m_mdr, m_y;
  logic [63:0] m_z;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] dut_value(input sel_e s);
    case (s)
      E_BUS:   return {32'd0, big_boy_bus};
      E_MDRIN: return {32'd0, MDR_data_in};
      E_R1:    return {32'd0, R1_data_out};
      E_R3:    return {32'd0, R3_data_out};
      E_R5:    return {32'd0, R5_data_out};
      E_PC:    return {32'd0, PC_data_out};
      E_IR:    return {32'd0, IR_data_out};
      E_MAR:   return {32'd0, MAR_data_out};
      E_MDR:   return {32'd0, MDR_data_out};
      E_Y:     return {32'd0, Y_data_out};
      default: return Z_data_out;
    endcase
  endfunction

  // Monitor: drains the scoreboard whenever outputs are stable.
  always begin
    exp_t e;
    @(negedge Clock or sample_ev);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check(e.name, dut_value(e.sel), e.val);
    end
  end

  task automatic push(input sel_e s, input logic [63:0] v, input string name);
    exp_t e;
    e.sel = s; e.val = v; e.name = name;
    sb.push_back(e);
  endtask

  task automatic push_regs(input string tag);
    push(E_R1,  {32'd0, m_r1},  {tag, "_r1"});
    push(E_R3,  {32'd0, m_r3},  {tag, "_r3"});
    push(E_R5,  {32'd0, m_r5},  {tag, "_r5"});
    push(E_PC,  {32'd0, m_pc},  {tag, "_pc"});
    push(E_IR,  {32'd0, m_ir},  {tag, "_ir"});
    push(E_MAR, {32'd0, m_mar}, {tag, "_mar"});
    push(E_MDR, {32'd0, m_mdr}, {tag, "_mdr"});
    push(E_Y,   {32'd0, m_y},   {tag, "_y"});
    push(E_Z,   m_z,            {tag, "_z"});
  endtask

  task automatic model_reset();
    m_r1 = '0; m_r3 = '0; m_r5 = '0; m_pc = '0; m_ir = '0;
    m_mar = '0; m_mdr = '0; m_y = '0; m_z = '0;
  endtask

  // Bus value from the select list, first match wins.
  function automatic logic [31:0] ref_bus(input ctrl_t c);
    if (c.mdrout) return m_mdr;
    if (c.pcout)  return m_pc;
    if (c.zloout) return m_z[31:0];
    if (c.r3out)  return m_r3;
    if (c.r5out)  return m_r5;
    return 32'd0;
  endfunction

  // ALU reference: shifts and rotates one bit position at a time,
  // signed arithmetic through 64-bit integers.
  function automatic logic [63:0] ref_alu(input logic [4:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    int          n;
    logic [31:0] t;
    longint      la, lb, q, r;
    n  = int'(b[4:0]);
    t  = a;
    la = longint'($signed(a));
    lb = longint'($signed(b));
    case (op)
      5'd0:  return {32'd0, a + b};
      5'd1:  return {32'd0, a - b};
      5'd2:  return {32'd0, a & b};
      5'd3:  return {32'd0, a | b};
      5'd4:  begin for (int i = 0; i < n; i++) t = {t[30:0], 1'b0};  return {32'd0, t}; end
      5'd5:  begin for (int i = 0; i < n; i++) t = {1'b0, t[31:1]};  return {32'd0, t}; end
      5'd6:  begin for (int i = 0; i < n; i++) t = {t[31], t[31:1]}; return {32'd0, t}; end
      5'd7:  begin for (int i = 0; i < n; i++) t = {t[0], t[31:1]};  return {32'd0, t}; end
      5'd8:  begin for (int i = 0; i < n; i++) t = {t[30:0], t[31]}; return {32'd0, t}; end
      5'd9:  return la * lb;
      5'd10: begin
        if (b == 32'd0) return 64'd0;
        q = la / lb;
        r = la % lb;
        return {r[31:0], q[31:0]};
      end
      5'd11: return {32'd0, 32'd0 - b};
      5'd12: return {32'd0, ~b};
      default: return 64'd0;
    endcase
  endfunction

  task automatic apply(input ctrl_t c);
    R1in = c.r1in; R3in = c.r3in; R5in = c.r5in;
    MARin = c.marin; Zin = c.zin; PCin = c.pcin; MDRin = c.mdrin; IRin = c.irin;
    Yin = c.yin; IncrementPC = c.incpc;
    PCout = c.pcout; ZLOout = c.zloout; MDRout = c.mdrout; R3out = c.r3out; R5out = c.r5out;
    Read = c.read; ALUControl = c.alu; Mdatain = c.mdata;
  endtask

  // One sequencer step, called just after a rising edge: drive controls,
  // predict the combinational outputs, clock, then predict register contents.
  task automatic cyc(input ctrl_t c, input string tag);
    logic [31:0] b, mdin;
    logic [63:0] alu;
    apply(c);
    b    = ref_bus(c);
    mdin = c.read ? c.mdata : b;
    alu  = ref_alu(c.alu, m_y, b);
    push(E_BUS, {32'd0, b}, {tag, "_bus"});
    push(E_MDRIN, {32'd0, mdin}, {tag, "_mdrin"});
    @(posedge Clock);
    if (c.r1in)  m_r1  = b;
    if (c.r3in)  m_r3  = b;
    if (c.r5in)  m_r5  = b;
    if (c.irin)  m_ir  = b;
    if (c.marin) m_mar = b;
    if (c.yin)   m_y   = b;
    if (c.mdrin) m_mdr = mdin;
    if (c.zin)   m_z   = alu;
    if (c.pcin)  m_pc  = c.incpc ? m_pc + 32'd1 : b;
    #1;
    push_regs(tag);
  endtask

  task automatic load_mdr(input logic [31:0] v, input string tag);
    ctrl_t c = '0;
    c.read = 1'b1; c.mdrin = 1'b1; c.mdata = v;
    cyc(c, tag);
  endtask

  task automatic load_y_via_mdr(input logic [31:0] v, input string tag);
    ctrl_t c = '0;
    load_mdr(v, tag);
    c.mdrout = 1'b1; c.yin = 1'b1;
    cyc(c, tag);
  endtask

  // Z = Y op R5 (R5 holds 0x2 during the directed op checks).
  task automatic op_r5(input logic [4:0] op, input logic [63:0] exp, input string tag);
    ctrl_t c = '0;
    c.r5out = 1'b1; c.zin = 1'b1; c.alu = op;
    cyc(c, tag);
    push(E_Z, exp, {tag, "_const"});
  endtask

  function automatic ctrl_t rand_ctrl();
    ctrl_t c = '0;
    c.r1in  = ($urandom_range(0, 3) == 0);
    c.r3in  = ($urandom_range(0, 3) == 0);
    c.r5in  = ($urandom_range(0, 3) == 0);
    c.marin = ($urandom_range(0, 3) == 0);
    c.zin   = ($urandom_range(0, 1) == 0);
    c.pcin  = ($urandom_range(0, 3) == 0);
    c.mdrin = ($urandom_range(0, 1) == 0);
    c.irin  = ($urandom_range(0, 3) == 0);
    c.yin   = ($urandom_range(0, 2) == 0);
    c.incpc = ($urandom_range(0, 1) == 0);
    c.read  = ($urandom_range(0, 1) == 0);
    case ($urandom_range(0, 6))
      0: ;
      1: c.mdrout = 1'b1;
      2: c.pcout  = 1'b1;
      3: c.zloout = 1'b1;
      4: c.r3out  = 1'b1;
      5: c.r5out  = 1'b1;
      default: begin
        c.r5out = 1'b1;
        case ($urandom_range(0, 3))
          0: c.mdrout = 1'b1;
          1: c.pcout  = 1'b1;
          2: c.zloout = 1'b1;
          default: c.r3out = 1'b1;
        endcase
      end
    endcase
    c.alu   = 5'($urandom_range(0, 15));
    c.mdata = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom();
    return c;
  endfunction

  // Clear asserted between edges with loads requested: registers must read 0
  // at once, and stay 0 across the following edge.
  task automatic do_clear(input string tag);
    ctrl_t c;
    c = rand_ctrl();
    c.r1in = 1'b1; c.r3in = 1'b1; c.mdrin = 1'b1; c.yin = 1'b1;
    c.zin = 1'b1; c.pcin = 1'b1; c.incpc = 1'b1;
    @(negedge Clock);
    #1;
    apply(c);
    Clear = 1'b1;
    #1;
    model_reset();
    push_regs({tag, "_async"});
    push(E_BUS, {32'd0, ref_bus(c)}, {tag, "_async_bus"});
    push(E_MDRIN, {32'd0, c.read ? c.mdata : 32'd0}, {tag, "_async_mdrin"});
    -> sample_ev;
    @(posedge Clock);
    #1;
    push_regs({tag, "_held"});
    -> sample_ev;
    #1;
    Clear = 1'b0;
    apply('0);
    @(posedge Clock);
    #1;
  endtask

  task automatic preload(input string tag);
    ctrl_t c;
    load_mdr(32'h12, {tag, "_m12"});
    c = '0; c.mdrout = 1'b1; c.r3in = 1'b1; cyc(c, {tag, "_r3"});
    push(E_R3, 64'h12, {tag, "_r3_const"});
    load_mdr(32'h2, {tag, "_m2"});
    c = '0; c.mdrout = 1'b1; c.r5in = 1'b1; cyc(c, {tag, "_r5"});
    push(E_R5, 64'h2, {tag, "_r5_const"});
    load_mdr(32'h18, {tag, "_m18"});
    c = '0; c.mdrout = 1'b1; c.r1in = 1'b1; cyc(c, {tag, "_r1"});
    push(E_R1, 64'h18, {tag, "_r1_const"});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    ctrl_t c;
    Clear = 1'b1;
    apply('0);
    model_reset();
    @(posedge Clock);
    #1;
    push_regs("reset");
    push(E_BUS, 64'd0, "reset_bus");
    @(negedge Clock);
    #1;
    Clear = 1'b0;
    @(posedge Clock);
    #1;

    preload("pre");

    // Fetch
    c = '0; c.pcout = 1'b1; c.marin = 1'b1; c.zin = 1'b1; cyc(c, "t0");
    push(E_MAR, 64'd0, "t0_mar_const");
    push(E_Z, 64'd0, "t0_z_const");
    c = '0; c.zloout = 1'b1; c.pcin = 1'b1; c.incpc = 1'b1; c.read = 1'b1;
    c.mdrin = 1'b1; c.mdata = 32'h2891_8000; cyc(c, "t1");
    push(E_PC, 64'd1, "t1_pc_const");
    push(E_MDR, 64'h2891_8000, "t1_mdr_const");
    c = '0; c.mdrout = 1'b1; c.irin = 1'b1; cyc(c, "t2");
    push(E_IR, 64'h2891_8000, "t2_ir_const");

    // Execute shl R1, R3, R5
    c = '0; c.r3out = 1'b1; c.yin = 1'b1; cyc(c, "t3");
    push(E_Y, 64'h12, "t3_y_const");
    op_r5(5'b00100, 64'h48, "t4_shl");
    c = '0; c.zloout = 1'b1; c.r1in = 1'b1; cyc(c, "t5");
    push(E_R1, 64'h48, "t5_r1_const");

    // Other operations with Y = 0x12, bus = R5 = 0x2
    op_r5(5'b00000, 64'h14, "add");
    op_r5(5'b00001, 64'h10, "sub");
    op_r5(5'b00010, 64'h2,  "and");
    op_r5(5'b00011, 64'h12, "or");
    op_r5(5'b00101, 64'h4,  "shr");
    op_r5(5'b01111, 64'h0,  "undef_op");
    load_y_via_mdr(32'h1, "ror_y");
    c = '0; c.mdrout = 1'b1; c.zin = 1'b1; c.alu = 5'b00111; cyc(c, "ror");
    push(E_Z, 64'h8000_0000, "ror_const");
    load_y_via_mdr(32'hFFFF_FFFF, "mul_y");
    op_r5(5'b01001, 64'hFFFF_FFFF_FFFF_FFFE, "mul");
    load_y_via_mdr(32'h7, "div_y");
    op_r5(5'b01010, 64'h0000_0001_0000_0003, "div");
    c = '0; c.zin = 1'b1; c.alu = 5'b01010; cyc(c, "div0");
    push(E_Z, 64'd0, "div0_const");

    // Bus priority: MDR beats R3; no select reads zero
    load_mdr(32'hA5A5_0001, "prio_m");
    c = '0; c.mdrout = 1'b1; c.r3out = 1'b1;
    push(E_BUS, 64'hA5A5_0001, "prio_mdr_over_r3");
    cyc(c, "prio");
    push(E_BUS, 64'd0, "no_select_bus");
    cyc('0, "idle");

    // Reset in the middle of a sequence, then preload again
    c = '0; c.r3out = 1'b1; c.yin = 1'b1; cyc(c, "mid");
    do_clear("clr1");
    preload("post");

    // Randomized traffic with one more reset in the middle
    for (int i = 0; i < 300; i++) begin
      if (i == 150) do_clear("clr2");
      cyc(rand_ctrl(), $sformatf("rnd%0d", i));
    end

    apply('0);
    @(negedge Clock);
    #1;
    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
